// File: rtl/angle_ctrl_pkg.sv
// angle_ctrl_pkg
// Shared types, Q-format constants and saturation helpers for the
// multi-axis angle/rate limiter.
//   state_e       one-hot controller state
//   FRAC          fractional bits of the Q.4 value format
//   CENTRE_SHIFT  left shift that maps an 8-bit stick count onto Q.4 scale
//   sat_to_width  saturate a signed value to a w-bit signed range
//   clamp_sym     clamp to [lo, L] where L = lim[w-2:0] and lo = 0 or -L
package angle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_CALC = 3'b010,
        ST_DONE = 3'b100
    } state_e;

    localparam int FRAC         = 4;
    localparam int CENTRE_SHIFT = 2;

    // Saturate x to the range of a w-bit two's complement number.
    function automatic logic signed [31:0] sat_to_width(
        input logic signed [31:0] x,
        input int                 w
    );
        logic signed [31:0] hi_s;
        logic signed [31:0] lo_s;
        logic signed [31:0] r_s;
        hi_s = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo_s = -hi_s - 32'sd1;
        if (x > hi_s) begin
            r_s = hi_s;
        end else if (x < lo_s) begin
            r_s = lo_s;
        end else begin
            r_s = x;
        end
        return r_s;
    endfunction

    // Clamp p to [lo, L]; the sign bit of the w-bit limit is discarded so
    // L is always a non-negative magnitude.
    function automatic logic signed [31:0] clamp_sym(
        input logic signed [31:0] p,
        input logic [31:0]        lim,
        input logic               unipolar,
        input int                 w
    );
        logic signed [31:0] hi_s;
        logic signed [31:0] lo_s;
        logic signed [31:0] r_s;
        hi_s = $signed(lim & ((32'd1 << (w - 1)) - 32'd1));
        lo_s = unipolar ? 32'sd0 : -hi_s;
        if (p > hi_s) begin
            r_s = hi_s;
        end else if (p < lo_s) begin
            r_s = lo_s;
        end else begin
            r_s = p;
        end
        return r_s;
    endfunction

endpackage

// File: rtl/multi_axis_angle_ctrl_axis_calc.sv
// axis_calc
// Combinational single-channel datapath: stick map, optional angle error,
// saturation, gain scaling and limit clamp.
//   target      in  REC_W   unsigned stick count
//   actual      in  VAL_W   IMU angle, signed Q.4
//   gain        in  GAIN_W  unsigned Q4.4 gain
//   limit       in  VAL_W   magnitude limit (MSB ignored)
//   angle_mode  in  1       subtract actual from the mapped target
//   unipolar    in  1       no centre offset, lower clamp 0
//   error       out VAL_W   pre-gain error saturated to VAL_W
//   rate        out VAL_W   clamped, scaled rate
//   sat         out 1       clamp changed the scaled value
module axis_calc
    import angle_ctrl_pkg::*;
#(
    parameter int REC_W      = 8,
    parameter int VAL_W      = 16,
    parameter int GAIN_W     = 8,
    parameter int REC_CENTRE = 125
) (
    input  logic [REC_W-1:0]  target,
    input  logic [VAL_W-1:0]  actual,
    input  logic [GAIN_W-1:0] gain,
    input  logic [VAL_W-1:0]  limit,
    input  logic              angle_mode,
    input  logic              unipolar,
    output logic [VAL_W-1:0]  error,
    output logic [VAL_W-1:0]  rate,
    output logic              sat
);

    localparam int W2 = VAL_W + 2;
    localparam int PW = VAL_W + GAIN_W + 1;
    localparam logic signed [W2-1:0] CENTRE_Q = W2'(REC_CENTRE <<< CENTRE_SHIFT);

    logic signed [W2-1:0]    m_s;
    logic signed [W2-1:0]    e_s;
    logic signed [VAL_W-1:0] esat_s;
    logic signed [PW-1:0]    prod_s;
    logic signed [PW-1:0]    p_s;
    logic signed [31:0]      clamp_s;

    // Map, error, scale and clamp one channel.
    always_comb begin
        m_s = $signed({{(W2 - REC_W - CENTRE_SHIFT){1'b0}}, target, {CENTRE_SHIFT{1'b0}}});
        if (!unipolar) begin
            m_s = m_s - CENTRE_Q;
        end else begin
            m_s = m_s;
        end
        if (angle_mode) begin
            e_s = m_s - $signed({{2{actual[VAL_W-1]}}, actual});
        end else begin
            e_s = m_s;
        end
        esat_s  = VAL_W'(sat_to_width(32'(e_s), VAL_W));
        // Gain is unsigned: a zero MSB keeps the signed multiply correct.
        prod_s  = PW'(esat_s) * PW'($signed({1'b0, gain}));
        p_s     = prod_s >>> FRAC;
        clamp_s = clamp_sym(32'(p_s), 32'(limit), unipolar, VAL_W);
    end

    assign error = esat_s;
    assign rate  = clamp_s[VAL_W-1:0];
    assign sat   = (clamp_s != 32'(p_s));

endmodule

// File: rtl/multi_axis_angle_ctrl.sv
// multi_axis_angle_ctrl
// Serial multi-channel angle/rate limiter. A request accepted in IDLE
// snapshots all inputs, walks the channels one per cycle through a shared
// axis_calc, and commits every output together with a one-cycle complete.
//   us_clk     in  1              clock
//   resetn     in  1              asynchronous active-low reset
//   start      in  1              request, sampled only in IDLE
//   target_in  in  NUM_CH*REC_W   stick targets, channel 0 in LSBs
//   actual_in  in  NUM_CH*VAL_W   IMU angles, signed Q.4
//   gain_in    in  NUM_CH*GAIN_W  per-channel Q4.4 gains
//   limit_in   in  NUM_CH*VAL_W   per-channel magnitude limits
//   rate_out   out NUM_CH*VAL_W   limited rates
//   error_out  out NUM_CH*VAL_W   saturated pre-gain error
//   sat_flags  out NUM_CH         per-channel clamp flags
//   active     out 1              high while channels are processed
//   complete   out 1              one-cycle commit pulse
module multi_axis_angle_ctrl
    import angle_ctrl_pkg::*;
#(
    parameter int                NUM_CH        = 4,
    parameter int                REC_W         = 8,
    parameter int                VAL_W         = 16,
    parameter int                GAIN_W        = 8,
    parameter int                REC_CENTRE    = 125,
    parameter logic [NUM_CH-1:0] ANGLE_MASK    = 4'b1100,
    parameter logic [NUM_CH-1:0] UNIPOLAR_MASK = 4'b0001
) (
    input  logic                       us_clk,
    input  logic                       resetn,
    input  logic                       start,
    input  logic [NUM_CH*REC_W-1:0]    target_in,
    input  logic [NUM_CH*VAL_W-1:0]    actual_in,
    input  logic [NUM_CH*GAIN_W-1:0]   gain_in,
    input  logic [NUM_CH*VAL_W-1:0]    limit_in,
    output logic [NUM_CH*VAL_W-1:0]    rate_out,
    output logic [NUM_CH*VAL_W-1:0]    error_out,
    output logic [NUM_CH-1:0]          sat_flags,
    output logic                       active,
    output logic                       complete
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [NUM_CH*REC_W-1:0]   tgt_q, tgt_d;
    logic [NUM_CH*VAL_W-1:0]   act_q, act_d;
    logic [NUM_CH*GAIN_W-1:0]  gain_q, gain_d;
    logic [NUM_CH*VAL_W-1:0]   lim_q, lim_d;
    logic [NUM_CH*VAL_W-1:0]   rate_sh_q, rate_sh_d;
    logic [NUM_CH*VAL_W-1:0]   err_sh_q, err_sh_d;
    logic [NUM_CH-1:0]         sat_sh_q, sat_sh_d;
    logic [NUM_CH*VAL_W-1:0]   rate_q, rate_d;
    logic [NUM_CH*VAL_W-1:0]   err_q, err_d;
    logic [NUM_CH-1:0]         sat_q, sat_d;
    logic                      active_q, active_d;
    logic                      complete_q, complete_d;

    logic [REC_W-1:0]          ch_tgt_s;
    logic [VAL_W-1:0]          ch_act_s;
    logic [GAIN_W-1:0]         ch_gain_s;
    logic [VAL_W-1:0]          ch_lim_s;
    logic [VAL_W-1:0]          ch_err_s;
    logic [VAL_W-1:0]          ch_rate_s;
    logic                      ch_sat_s;

    assign ch_tgt_s  = tgt_q[int'(idx_q)*REC_W +: REC_W];
    assign ch_act_s  = act_q[int'(idx_q)*VAL_W +: VAL_W];
    assign ch_gain_s = gain_q[int'(idx_q)*GAIN_W +: GAIN_W];
    assign ch_lim_s  = lim_q[int'(idx_q)*VAL_W +: VAL_W];

    axis_calc #(
        .REC_W      (REC_W),
        .VAL_W      (VAL_W),
        .GAIN_W     (GAIN_W),
        .REC_CENTRE (REC_CENTRE)
    ) u_axis_calc (
        .target     (ch_tgt_s),
        .actual     (ch_act_s),
        .gain       (ch_gain_s),
        .limit      (ch_lim_s),
        .angle_mode (ANGLE_MASK[idx_q]),
        .unipolar   (UNIPOLAR_MASK[idx_q]),
        .error      (ch_err_s),
        .rate       (ch_rate_s),
        .sat        (ch_sat_s)
    );

    // Next-state, snapshot, shadow and commit logic.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tgt_d     = tgt_q;
        act_d     = act_q;
        gain_d    = gain_q;
        lim_d     = lim_q;
        rate_sh_d = rate_sh_q;
        err_sh_d  = err_sh_q;
        sat_sh_d  = sat_sh_q;
        rate_d    = rate_q;
        err_d     = err_q;
        sat_d     = sat_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CALC;
                    idx_d   = '0;
                    tgt_d   = target_in;
                    act_d   = actual_in;
                    gain_d  = gain_in;
                    lim_d   = limit_in;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                rate_sh_d[int'(idx_q)*VAL_W +: VAL_W] = ch_rate_s;
                err_sh_d[int'(idx_q)*VAL_W +: VAL_W]  = ch_err_s;
                sat_sh_d[idx_q]                       = ch_sat_s;
                if (idx_q == LAST_IDX) begin
                    // Commit takes the shadow including the channel
                    // finishing this cycle.
                    state_d = ST_DONE;
                    idx_d   = '0;
                    rate_d  = rate_sh_d;
                    err_d   = err_sh_d;
                    sat_d   = sat_sh_d;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
        active_d   = (state_d == ST_CALC);
        complete_d = (state_d == ST_DONE);
    end

    // State, data and output registers.
    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            tgt_q      <= '0;
            act_q      <= '0;
            gain_q     <= '0;
            lim_q      <= '0;
            rate_sh_q  <= '0;
            err_sh_q   <= '0;
            sat_sh_q   <= '0;
            rate_q     <= '0;
            err_q      <= '0;
            sat_q      <= '0;
            active_q   <= 1'b0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tgt_q      <= tgt_d;
            act_q      <= act_d;
            gain_q     <= gain_d;
            lim_q      <= lim_d;
            rate_sh_q  <= rate_sh_d;
            err_sh_q   <= err_sh_d;
            sat_sh_q   <= sat_sh_d;
            rate_q     <= rate_d;
            err_q      <= err_d;
            sat_q      <= sat_d;
            active_q   <= active_d;
            complete_q <= complete_d;
        end
    end

    assign rate_out  = rate_q;
    assign error_out = err_q;
    assign sat_flags = sat_q;
    assign active    = active_q;
    assign complete  = complete_q;

endmodule

// File: tb/tb_multi_axis_angle_ctrl.sv
// Testbench for multi_axis_angle_ctrl: directed vector table, hand-written
// protocol sequences and randomized transactions against a reference model.
module tb_multi_axis_angle_ctrl;

    logic        us_clk;
    logic        resetn;
    logic        start;
    logic [31:0] target_in;
    logic [63:0] actual_in;
    logic [31:0] gain_in;
    logic [63:0] limit_in;
    logic [63:0] rate_out;
    logic [63:0] error_out;
    logic [3:0]  sat_flags;
    logic        active;
    logic        complete;

    logic [3:0]  ang_m = 4'b1100;
    logic [3:0]  uni_m = 4'b0001;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [31:0] tg;
        logic [63:0] ac;
        logic [31:0] gn;
        logic [63:0] lm;
        logic [63:0] er;
        logic [63:0] ee;
        logic [3:0]  es;
    } vec_t;

    vec_t vecs [4];

    multi_axis_angle_ctrl dut (
        .us_clk    (us_clk),
        .resetn    (resetn),
        .start     (start),
        .target_in (target_in),
        .actual_in (actual_in),
        .gain_in   (gain_in),
        .limit_in  (limit_in),
        .rate_out  (rate_out),
        .error_out (error_out),
        .sat_flags (sat_flags),
        .active    (active),
        .complete  (complete)
    );

    initial us_clk = 1'b0;
    always #5 us_clk = ~us_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic scramble();
        target_in = $urandom;
        actual_in = {$urandom, $urandom};
        gain_in   = $urandom;
        limit_in  = {$urandom, $urandom};
    endtask

    // Reference: stick*4, minus 500 when bipolar, minus angle when in
    // angle mode, saturate to 16 bits, scale by gain/16 rounding toward
    // minus infinity, clamp to [0 or -L, L].
    function automatic void model_ch(input int k, input logic [7:0] t, input logic [15:0] a,
                                     input logic [7:0] g, input logic [15:0] l,
                                     output logic [15:0] e_o, output logic [15:0] r_o,
                                     output logic s_o);
        int m, e, p, lim, lo, r;
        m = int'(t) * 4;
        if (!uni_m[k]) m = m - 500;
        if (ang_m[k]) m = m - int'($signed(a));
        e = m;
        if (e > 32767) e = 32767;
        if (e < -32768) e = -32768;
        p = (e * int'(g)) >>> 4;
        lim = int'(l & 16'h7FFF);
        lo = uni_m[k] ? 0 : -lim;
        r = p;
        if (r > lim) r = lim;
        else if (r < lo) r = lo;
        e_o = e[15:0];
        r_o = r[15:0];
        s_o = (r != p);
    endfunction

    task automatic run_txn(input logic [31:0] tg, input logic [63:0] ac, input logic [31:0] gn,
                           input logic [63:0] lm, input logic [63:0] er, input logic [63:0] ee,
                           input logic [3:0] es, input string tag);
        int lat, act_cnt;
        bit seen;
        @(negedge us_clk);
        target_in = tg;
        actual_in = ac;
        gain_in   = gn;
        limit_in  = lm;
        start     = 1'b1;
        @(posedge us_clk);
        @(negedge us_clk);
        start = 1'b0;
        scramble();
        lat = 0;
        act_cnt = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            if (active) act_cnt++;
            @(posedge us_clk);
            lat++;
            @(negedge us_clk);
            if (complete) seen = 1'b1;
        end
        chk({tag, " latency"}, 64'(lat), 64'd4);
        chk({tag, " active_cycles"}, 64'(act_cnt), 64'd4);
        chk({tag, " active_after"}, 64'(active), 64'd0);
        chk({tag, " rate"}, rate_out, er);
        chk({tag, " error"}, error_out, ee);
        chk({tag, " sat"}, 64'(sat_flags), 64'(es));
        @(posedge us_clk);
        @(negedge us_clk);
        chk({tag, " complete_fall"}, 64'(complete), 64'd0);
        scramble();
        repeat (3) @(negedge us_clk);
        chk({tag, " hold"}, rate_out, er);
    endtask

    initial begin
        logic [31:0] tg, gn;
        logic [63:0] ac, lm, er, ee;
        logic [3:0]  es;
        logic [15:0] e1, r1;
        logic        s1;
        int          cnt;

        vecs[0] = '{tg: 32'h7D7D7D7D, ac: 64'h0, gn: 32'h10101010,
                    lm: 64'h0190_0190_0190_0FC0,
                    er: 64'h0000_0000_0000_01F4, ee: 64'h0000_0000_0000_01F4, es: 4'b0000};
        vecs[1] = '{tg: 32'h7DFA7D7D, ac: 64'h0000_0050_0000_0000, gn: 32'h10101010,
                    lm: 64'h0190_0190_0190_0FC0,
                    er: 64'h0000_0190_0000_01F4, ee: 64'h0000_01A4_0000_01F4, es: 4'b0100};
        vecs[2] = '{tg: 32'h007D7D7D, ac: 64'h0, gn: 32'h08101010,
                    lm: 64'h0190_0190_0190_0FC0,
                    er: 64'hFF06_0000_0000_01F4, ee: 64'hFE0C_0000_0000_01F4, es: 4'b0000};
        vecs[3] = '{tg: 32'h7DFA7D7D, ac: 64'h0000_8000_0000_0000, gn: 32'h10101010,
                    lm: 64'h0190_0190_0190_0000,
                    er: 64'h0000_0190_0000_0000, ee: 64'h0000_7FFF_0000_01F4, es: 4'b0101};

        // Reset held while inputs and start toggle.
        resetn = 1'b0;
        start = 1'b0;
        target_in = '0;
        actual_in = '0;
        gain_in = '0;
        limit_in = '0;
        repeat (4) begin
            @(negedge us_clk);
            scramble();
            start = 1'($urandom);
        end
        chk("rst rate", rate_out, 64'h0);
        chk("rst error", error_out, 64'h0);
        chk("rst sat", 64'(sat_flags), 64'h0);
        chk("rst active", 64'(active), 64'h0);
        chk("rst complete", 64'(complete), 64'h0);
        @(negedge us_clk);
        start = 1'b0;
        resetn = 1'b1;
        repeat (2) @(negedge us_clk);
        chk("post_rst rate", rate_out, 64'h0);
        chk("post_rst active", 64'(active), 64'h0);

        // Directed vector table.
        for (int i = 0; i < 4; i++) begin
            run_txn(vecs[i].tg, vecs[i].ac, vecs[i].gn, vecs[i].lm,
                    vecs[i].er, vecs[i].ee, vecs[i].es, $sformatf("vec%0d", i));
        end

        // start held through CALC and DONE: exactly one completion.
        @(negedge us_clk);
        target_in = vecs[0].tg;
        actual_in = vecs[0].ac;
        gain_in   = vecs[0].gn;
        limit_in  = vecs[0].lm;
        start     = 1'b1;
        cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge us_clk);
            @(negedge us_clk);
            if (complete) cnt++;
        end
        start = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge us_clk);
            @(negedge us_clk);
            if (complete) cnt++;
        end
        chk("start_ignored completes", 64'(cnt), 64'd1);
        chk("start_ignored rate", rate_out, vecs[0].er);

        // Reset dropped at CALC index 2.
        @(negedge us_clk);
        target_in = vecs[1].tg;
        actual_in = vecs[1].ac;
        gain_in   = vecs[1].gn;
        limit_in  = vecs[1].lm;
        start     = 1'b1;
        @(posedge us_clk);
        @(negedge us_clk);
        start = 1'b0;
        @(posedge us_clk);
        @(posedge us_clk);
        @(negedge us_clk);
        resetn = 1'b0;
        #1;
        chk("abort rate", rate_out, 64'h0);
        chk("abort error", error_out, 64'h0);
        chk("abort sat", 64'(sat_flags), 64'h0);
        chk("abort active", 64'(active), 64'h0);
        repeat (2) @(negedge us_clk);
        resetn = 1'b1;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge us_clk);
            @(negedge us_clk);
            if (complete) cnt++;
        end
        chk("abort no_complete", 64'(cnt), 64'd0);
        chk("abort rate_held", rate_out, 64'h0);
        run_txn(vecs[1].tg, vecs[1].ac, vecs[1].gn, vecs[1].lm,
                vecs[1].er, vecs[1].ee, vecs[1].es, "after_abort");

        // Randomized transactions against the reference model.
        for (int i = 0; i < 25; i++) begin
            tg = $urandom;
            ac = {$urandom, $urandom};
            gn = $urandom;
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 2) == 0) lm[k*16 +: 16] = 16'($urandom_range(0, 600));
                else lm[k*16 +: 16] = 16'($urandom);
                if ($urandom_range(0, 1) == 0) ac[k*16 +: 16] = 16'($signed(12'($urandom)));
            end
            es = '0;
            for (int k = 0; k < 4; k++) begin
                model_ch(k, tg[k*8 +: 8], ac[k*16 +: 16], gn[k*8 +: 8], lm[k*16 +: 16], e1, r1, s1);
                ee[k*16 +: 16] = e1;
                er[k*16 +: 16] = r1;
                es[k] = s1;
            end
            run_txn(tg, ac, gn, lm, er, ee, es, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
